// File: rtl/fab_muldiv.sv
// RV32M/RV64M multiply/divide execute unit: fixed-latency multiply and a restoring divider.
// Define FAB_MULDIV_EARLY_OUT_EN to finish trivial divides (zero divisor, overflow, |a|<|b|) in one cycle.
module fab_muldiv #(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned MUL_LAT = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stop,
  input  logic              flush,
  input  logic              valid_in,
  output logic              ready_in,
  input  logic              num_in,
  input  logic [2:0]        op,
  input  logic [4:0]        rd,
  input  logic [XLEN-1:0]   rs1_data,
  input  logic [XLEN-1:0]   rs2_data,
  output logic              busy,
  output logic              valid_out,
  output logic              num_out,
  output logic [XLEN+6:0]   rfw
);

  localparam int unsigned CW = $clog2(XLEN);
  localparam logic [CW-1:0] MulCnt = CW'((MUL_LAT >= 2) ? MUL_LAT - 2 : 0);
  localparam logic [CW-1:0] DivCnt = CW'(XLEN - 1);

  typedef enum logic [2:0] {StIdle, StMul, StDiv, StFix, StDone} state_e;

  state_e            r_state, w_state_d;
  logic [2:0]        r_op;
  logic [XLEN-1:0]   r_a, r_b, r_quo, r_rem, r_res, r_last_data;
  logic [4:0]        r_rd, r_last_rd;
  logic              r_num, r_last_num;
  logic [CW-1:0]     r_cnt;

  // In IDLE the issue-side operands feed the datapath so single-cycle paths can finish on accept.
  logic              w_idle;
  logic [2:0]        w_op;
  logic [XLEN-1:0]   w_a, w_b;
  assign w_idle = (r_state == StIdle);
  assign w_op   = w_idle ? op : r_op;
  assign w_a    = w_idle ? rs1_data : r_a;
  assign w_b    = w_idle ? rs2_data : r_b;

  logic [XLEN:0]     w_ma, w_mb;
  logic [2*XLEN-1:0] w_prod;
  logic [XLEN-1:0]   w_mul_res;
  assign w_ma      = {(w_op[1:0] != 2'd3) & w_a[XLEN-1], w_a};
  assign w_mb      = {~w_op[1] & w_b[XLEN-1], w_b};
  assign w_prod    = {{(XLEN-1){w_ma[XLEN]}}, w_ma} * {{(XLEN-1){w_mb[XLEN]}}, w_mb};
  assign w_mul_res = (w_op[1:0] == 2'd0) ? w_prod[XLEN-1:0] : w_prod[2*XLEN-1:XLEN];

  logic              w_sgn, w_is_rem, w_a_neg, w_b_neg, w_b_zero, w_ovf, w_early;
  logic [XLEN-1:0]   w_a_mag, w_b_mag, w_spec, w_q_fix, w_r_fix, w_div_res;
  logic [XLEN:0]     w_trial;
  assign w_sgn     = ~w_op[0];
  assign w_is_rem  = w_op[1];
  assign w_a_neg   = w_sgn & w_a[XLEN-1];
  assign w_b_neg   = w_sgn & w_b[XLEN-1];
  assign w_a_mag   = w_a_neg ? -w_a : w_a;
  assign w_b_mag   = w_b_neg ? -w_b : w_b;
  assign w_b_zero  = (w_b == '0);
  assign w_ovf     = w_sgn && (w_a == {1'b1, {(XLEN-1){1'b0}}}) && (w_b == '1);
  assign w_trial   = {r_rem, r_quo[XLEN-1]} - {1'b0, w_b_mag};
  assign w_q_fix   = (w_a_neg ^ w_b_neg) ? -r_quo : r_quo;
  assign w_r_fix   = w_a_neg ? -r_rem : r_rem;
  assign w_div_res = (w_b_zero || w_ovf) ? w_spec : (w_is_rem ? w_r_fix : w_q_fix);

`ifdef FAB_MULDIV_EARLY_OUT_EN
  logic w_small;
  assign w_small = (w_a_mag < w_b_mag);
  assign w_early = w_b_zero | w_ovf | w_small;
`else
  assign w_early = 1'b0;
`endif

  // Last branch is the |a| < |b| shortcut: quotient 0, remainder is the dividend.
  always_comb begin
    w_spec = '0;
    if (w_b_zero)  w_spec = w_is_rem ? w_a : '1;
    else if (w_ovf) w_spec = w_is_rem ? '0 : w_a;
    else           w_spec = w_is_rem ? w_a : '0;
  end

  always_comb begin
    w_state_d = r_state;
    case (r_state)
      StIdle: begin
        if (valid_in) begin
          if (!op[2]) w_state_d = (MUL_LAT == 1) ? StDone : StMul;
          else        w_state_d = w_early ? StDone : StDiv;
        end
      end
      StMul:  if (r_cnt == '0) w_state_d = StDone;
      StDiv:  if (r_cnt == '0) w_state_d = StFix;
      StFix:  w_state_d = StDone;
      StDone: w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase
    if (stop)  w_state_d = r_state;
    if (flush) w_state_d = StIdle;
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= StIdle;
    else     r_state <= w_state_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_op        <= '0;
      r_a         <= '0;
      r_b         <= '0;
      r_rd        <= '0;
      r_num       <= 1'b0;
      r_cnt       <= '0;
      r_quo       <= '0;
      r_rem       <= '0;
      r_res       <= '0;
      r_last_data <= '0;
      r_last_rd   <= '0;
      r_last_num  <= 1'b0;
    end else if (!flush && !stop) begin
      case (r_state)
        StIdle: begin
          if (valid_in) begin
            r_op  <= op;
            r_a   <= rs1_data;
            r_b   <= rs2_data;
            r_rd  <= rd;
            r_num <= num_in;
            r_cnt <= op[2] ? DivCnt : MulCnt;
            r_quo <= w_a_mag;
            r_rem <= '0;
            if (!op[2] && (MUL_LAT == 1)) r_res <= w_mul_res;
            if (op[2] && w_early)         r_res <= w_spec;
          end
        end
        StMul: begin
          if (r_cnt == '0) r_res <= w_mul_res;
          else             r_cnt <= r_cnt - CW'(1);
        end
        StDiv: begin
          if (!w_trial[XLEN]) begin
            r_rem <= w_trial[XLEN-1:0];
            r_quo <= {r_quo[XLEN-2:0], 1'b1};
          end else begin
            r_rem <= {r_rem[XLEN-2:0], r_quo[XLEN-1]};
            r_quo <= {r_quo[XLEN-2:0], 1'b0};
          end
          if (r_cnt != '0) r_cnt <= r_cnt - CW'(1);
        end
        StFix: r_res <= w_div_res;
        StDone: begin
          r_last_data <= r_res;
          r_last_rd   <= r_rd;
          r_last_num  <= r_num;
        end
        default: ;
      endcase
    end
  end

  logic w_we;
  assign valid_out = (r_state == StDone) && !flush;
  assign ready_in  = w_idle;
  assign busy      = !w_idle;
  assign w_we      = valid_out && (r_rd != 5'd0);
  assign num_out   = valid_out ? r_num : r_last_num;
  assign rfw       = {w_we, 1'b1, valid_out ? r_rd : r_last_rd, valid_out ? r_res : r_last_data};

endmodule

// File: tb/tb_fab_muldiv.sv
// Self-checking bench for fab_muldiv: directed vector table, corner sequences, random vs model.
module tb_fab_muldiv;
  localparam int XLEN    = 32;
  localparam int MUL_LAT = 2;
`ifdef FAB_MULDIV_EARLY_OUT_EN
  localparam bit Early = 1'b1;
`else
  localparam bit Early = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst, stop, flush, valid_in, ready_in, num_in, busy, valid_out, num_out;
  logic [2:0]  op;
  logic [4:0]  rd;
  logic [31:0] rs1, rs2;
  logic [38:0] rfw;

  fab_muldiv #(.XLEN(XLEN), .MUL_LAT(MUL_LAT)) dut (
    .clk(clk), .rst(rst), .stop(stop), .flush(flush), .valid_in(valid_in),
    .ready_in(ready_in), .num_in(num_in), .op(op), .rd(rd), .rs1_data(rs1),
    .rs2_data(rs2), .busy(busy), .valid_out(valid_out), .num_out(num_out), .rfw(rfw)
  );

  always #5 clk = ~clk;

  int          total = 0;
  int          bad   = 0;
  logic [31:0] last_d;
  logic [4:0]  last_rd;
  logic        last_num;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    logic        num;
    logic [31:0] exp;
  } vec_t;
  vec_t vecs[15];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] ref_res(input logic [2:0] o, input logic [31:0] a,
                                          input logic [31:0] b);
    longint sa = $signed(a);
    longint sb = $signed(b);
    longint ua = {32'd0, a};
    longint ub = {32'd0, b};
    longint p;
    case (o)
      3'd0: p = sa * sb;
      3'd1: p = sa * sb >>> 32;
      3'd2: p = sa * ub >>> 32;
      3'd3: p = ua * ub >> 32;
      3'd4: p = (b == 0) ? -1 : (a == 32'h80000000 && b == 32'hFFFFFFFF) ? sa : sa / sb;
      3'd5: p = (b == 0) ? -1 : ua / ub;
      3'd6: p = (b == 0) ? sa : (a == 32'h80000000 && b == 32'hFFFFFFFF) ? 0 : sa % sb;
      default: p = (b == 0) ? ua : ua % ub;
    endcase
    return p[31:0];
  endfunction

  function automatic int exp_lat(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    longint ma, mb;
    bit     sgn = !o[0];
    if (!o[2]) return MUL_LAT;
    ma = sgn ? $signed(a) : {32'd0, a};
    mb = sgn ? $signed(b) : {32'd0, b};
    if (ma < 0) ma = -ma;
    if (mb < 0) mb = -mb;
    if (Early && (b == 0 || (sgn && a == 32'h80000000 && b == 32'hFFFFFFFF) || ma < mb))
      return 1;
    return XLEN + 2;
  endfunction

  // Called one step after a rising edge with the unit idle; stop_at > 0 freezes 3 cycles there.
  task automatic do_op(input string nm, input logic [2:0] o, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] r, input logic n,
                       input logic [31:0] exp_d, input int stop_at);
    int c;
    bit busy_ok = 1'b1;
    int lat_e = exp_lat(o, a, b) + ((stop_at > 0) ? 3 : 0);
    op = o; rs1 = a; rs2 = b; rd = r; num_in = n; valid_in = 1'b1;
    @(posedge clk); #1;
    valid_in = 1'b0; op = 3'($urandom); rs1 = $urandom; rs2 = $urandom; rd = 5'($urandom);
    num_in = ~n;
    c = 1;
    while (!valid_out && c < 200) begin
      if (!busy) busy_ok = 1'b0;
      if (stop_at > 0) stop = (c >= stop_at) && (c < stop_at + 3);
      @(posedge clk); #1;
      c++;
    end
    stop = 1'b0;
    chk({nm, " latency"}, c, lat_e);
    chk({nm, " data"}, rfw[31:0], exp_d);
    chk({nm, " we"}, rfw[38], r != 5'd0);
    chk({nm, " addr"}, rfw[37:32], {1'b1, r});
    chk({nm, " num"}, num_out, n);
    chk({nm, " busy"}, busy_ok, 1'b1);
    @(posedge clk); #1;
    chk({nm, " ready after"}, {valid_out, ready_in, rfw[38], rfw[31:0]}, {3'b010, exp_d});
    last_d = exp_d; last_rd = r; last_num = n;
  endtask

  initial begin
    int c;
    bit seen;
    rst = 1'b1; stop = 1'b0; flush = 1'b0; valid_in = 1'b0; num_in = 1'b0;
    op = '0; rd = '0; rs1 = '0; rs2 = '0;
    vecs[0]  = '{3'd0, 32'd7,        32'hFFFFFFFD, 5'd5,  1'b1, 32'hFFFFFFEB};
    vecs[1]  = '{3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd6,  1'b0, 32'hFFFFFFFE};
    vecs[2]  = '{3'd2, 32'hFFFFFFFF, 32'd2,        5'd7,  1'b1, 32'hFFFFFFFF};
    vecs[3]  = '{3'd1, 32'h80000000, 32'h80000000, 5'd8,  1'b0, 32'h40000000};
    vecs[4]  = '{3'd4, 32'hFFFFFFEC, 32'd6,        5'd9,  1'b1, 32'hFFFFFFFD};
    vecs[5]  = '{3'd6, 32'hFFFFFFEC, 32'd6,        5'd10, 1'b0, 32'hFFFFFFFE};
    vecs[6]  = '{3'd5, 32'd5,        32'd0,        5'd11, 1'b1, 32'hFFFFFFFF};
    vecs[7]  = '{3'd6, 32'd5,        32'd0,        5'd12, 1'b0, 32'd5};
    vecs[8]  = '{3'd4, 32'h80000000, 32'hFFFFFFFF, 5'd13, 1'b1, 32'h80000000};
    vecs[9]  = '{3'd6, 32'h80000000, 32'hFFFFFFFF, 5'd14, 1'b0, 32'd0};
    vecs[10] = '{3'd7, 32'd100,      32'd7,        5'd15, 1'b1, 32'd2};
    vecs[11] = '{3'd5, 32'd3,        32'd10,       5'd16, 1'b0, 32'd0};
    vecs[12] = '{3'd0, 32'd2,        32'd3,        5'd0,  1'b1, 32'd6};
    vecs[13] = '{3'd4, 32'd7,        32'hFFFFFFFE, 5'd17, 1'b0, 32'hFFFFFFFD};
    vecs[14] = '{3'd6, 32'd7,        32'hFFFFFFFE, 5'd18, 1'b1, 32'd1};

    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Reset while dividing: must abort silently.
    op = 3'd4; rs1 = 32'd1000; rs2 = 32'd3; rd = 5'd4; num_in = 1'b1; valid_in = 1'b1;
    @(posedge clk); #1 valid_in = 1'b0;
    repeat (5) @(posedge clk);
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("reset state", {valid_out, ready_in, busy, num_out, rfw}, {4'b0100, 1'b0, 1'b1, 37'd0});
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (valid_out) seen = 1'b1;
    end
    chk("reset abort", seen, 1'b0);
    last_d = '0; last_rd = '0; last_num = 1'b0;

    foreach (vecs[i])
      do_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].rd, vecs[i].num,
            vecs[i].exp, 0);

    do_op("div stop", 3'd4, 32'hFFFFFFEC, 32'd6, 5'd19, 1'b1, 32'hFFFFFFFD, 10);

    // Flush in the DONE cycle; a valid_in in that cycle is ignored.
    op = 3'd0; rs1 = 32'd7; rs2 = 32'hFFFFFFFD; rd = 5'd9; num_in = ~last_num; valid_in = 1'b1;
    @(posedge clk); #1 valid_in = 1'b0;
    c = 1;
    while (!valid_out && c < 20) begin
      @(posedge clk); #1 c++;
    end
    chk("flush reach done", c, MUL_LAT);
    flush = 1'b1; valid_in = 1'b1;
    #1;
    chk("flush valid", {valid_out, rfw[38]}, 2'b00);
    @(posedge clk); #1;
    flush = 1'b0; valid_in = 1'b0;
    chk("flush after", {valid_out, ready_in, busy, num_out}, {3'b010, last_num});
    chk("flush held result", rfw[36:0], {last_rd, last_d});

    // Back-to-back: valid_in held high through DONE.
    op = 3'd0; rs1 = 32'd2; rs2 = 32'd5; rd = 5'd3; num_in = 1'b0; valid_in = 1'b1;
    @(posedge clk); #1;
    c = 1;
    while (!valid_out && c < 20) begin
      @(posedge clk); #1 c++;
    end
    chk("b2b first", {c, rfw[31:0]}, {MUL_LAT, 32'd10});
    rs1 = 32'd4; rs2 = 32'd6; num_in = 1'b1;
    c = 0;
    do begin
      @(posedge clk); #1 c++;
    end while (!valid_out && c < 20);
    valid_in = 1'b0;
    chk("b2b gap", c, MUL_LAT + 1);
    chk("b2b second", {num_out, rfw[31:0]}, {1'b1, 32'd24});
    @(posedge clk); #1;
    last_d = 32'd24; last_rd = 5'd3; last_num = 1'b1;

    for (int i = 0; i < 40; i++) begin
      logic [2:0]  ro;
      logic [31:0] ra, rb;
      ro = 3'($urandom_range(0, 7));
      case ($urandom_range(0, 5))
        0, 1: ra = $urandom;
        2:    ra = $urandom_range(0, 40);
        3:    ra = -$urandom_range(1, 40);
        4:    ra = 32'h80000000;
        default: ra = 32'hFFFFFFFF;
      endcase
      case ($urandom_range(0, 6))
        0, 1: rb = $urandom;
        2:    rb = $urandom_range(1, 40);
        3:    rb = -$urandom_range(1, 40);
        4:    rb = 32'd0;
        default: rb = 32'hFFFFFFFF;
      endcase
      do_op($sformatf("rnd%0d", i), ro, ra, rb, 5'($urandom), 1'($urandom), ref_res(ro, ra, rb), 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/fab_muldiv.md
Name: fab_muldiv

Overview:
- Parametrised multi-cycle execute unit for the RV32M/RV64M multiply and divide instructions; it sits beside the single-cycle ALU/branch execute slot in the dual-issue pipeline.
- Accepts one operation per handshake from issue and carries the issue order tag (`num`).
- Multiplies complete in a fixed pipelined latency; divides use a restoring iterative divider.
- Results leave on the standard regfile-write bus `{we, 1'b1, addr, data}` for writeback.

Parameters:
- XLEN, 32, operand/result width (32 or 64).
- MUL_LAT, 2, cycles from accept to valid_out for multiply ops; range 1..4.

Ports:
- clk  input  1  clock.
- rst  input  1  reset, synchronous, active-high.
- stop  input  1  pipeline freeze: all state and outputs hold.
- flush  input  1  kill the in-flight op and return to IDLE.
- valid_in  input  1  op presented.
- ready_in  output  1  unit can accept (state IDLE).
- num_in  input  1  issue order tag.
- op  input  3  funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- rd  input  5  destination register.
- rs1_data  input  XLEN  operand A.
- rs2_data  input  XLEN  operand B.
- busy  output  1  op in flight (issue stall request).
- valid_out  output  1  result valid this cycle.
- num_out  output  1  tag of the result.
- rfw  output  XLEN+7  `{we, 1'b1, addr[4:0], data[XLEN-1:0]}`.

Behaviour:
- Clocking and reset: single clock `clk`. Reset `rst` is synchronous and active-high.
- Reset values:
  - state = IDLE, ready_in = 1, busy = 0, valid_out = 0, num_out = 0.
  - rfw = `{0, 1, 5'b0, 0}`.
  - Reset mid-operation aborts with no result.
- Priority: rst > flush > stop > normal.
- States: IDLE, MUL, DIV, FIX, DONE.
- Accept: valid_in && ready_in && !stop && !flush. Latch op, rd, num_in and operands.
- IDLE -> MUL for op < 4, or -> DIV for op >= 4.
- MUL:
  - Full 2*XLEN product of sign-adjusted operands. MULHSU treats rs1 as signed and rs2 as unsigned.
  - A counter of MUL_LAT-1 cycles, then -> DONE.
  - valid_out asserts exactly MUL_LAT cycles after the accept edge.
  - MUL returns the low XLEN bits; the MULH variants return the high XLEN bits.
- DIV:
  - Operates on magnitudes for signed ops.
  - One quotient bit per cycle, counter XLEN-1 down to 0, then -> FIX.
- FIX: apply signs. Quotient is negated when the operand signs differ; remainder takes the sign of the dividend. Then -> DONE.
- Divide latency: valid_out at accept+XLEN+2.
- Division by zero: quotient = all ones; remainder = rs1.
- Signed overflow (most-negative / -1): quotient = rs1; remainder = 0.
- DONE:
  - valid_out = 1 for one cycle; while stop is high it holds.
  - Next state IDLE. A new accept is possible in the following cycle, with no overlap.
- ready_in = (state == IDLE). busy = (state != IDLE).
- rfw:
  - we = valid_out && (rd != 0). Bit XLEN+5 is always 1.
  - addr and data hold the last result when valid_out = 0.
  - num_out is updated together with the result.
- flush:
  - Any state -> IDLE next cycle; valid_out = 0.
  - A flush in the DONE cycle suppresses that result. valid_in in the same cycle is ignored.
- stop: counters, state, operands and outputs all frozen; no accept.
- Back-pressure: none beyond stop; writeback always consumes valid_out.

Optional Feature:
- Macro: FAB_MULDIV_EARLY_OUT_EN.
- Defined:
  - A divide with rs2 == 0 or signed overflow skips DIV/FIX: IDLE -> DONE, so valid_out is at accept+1.
  - A divide with |rs1| < |rs2| also goes to DONE directly: quotient 0, remainder = rs1, valid_out at accept+1.
- Undefined: all divides take XLEN+2 cycles. Special-case results are identical in both builds.

Test Plan:
- Reset check: rst held 2 cycles in the DIV state, then released. Expect valid_out = 0, ready_in = 1, busy = 0, rfw = `{0, 1, 0, 0}`.
- MUL: op = 0, rs1 = 7, rs2 = -3, rd = 5, num_in = 1, MUL_LAT = 2.
  - valid_out exactly 2 cycles after accept.
  - rfw = `{1, 1, 5, 32'hFFFFFFEB}`, num_out = 1.
- MULHU: op = 3, rs1 = rs2 = 32'hFFFFFFFF. Expect data 32'hFFFFFFFE.
- MULHSU: op = 2, rs1 = -1, rs2 = 2. Expect data 32'hFFFFFFFF.
- DIV: op = 4, rs1 = -20, rs2 = 6. Expect quotient -3 at accept+34; busy high throughout.
- REM: op = 6, same operands. Expect data -2.
- Divide special cases:
  - DIVU 5/0 -> 32'hFFFFFFFF.
  - REM 5/0 -> 5.
  - DIV 32'h80000000/-1 -> 32'h80000000.
  - Latency: 34 cycles without FAB_MULDIV_EARLY_OUT_EN, 1 cycle with it.
- Freeze and kill:
  - stop pulsed for 3 cycles mid-DIV: valid_out delayed by exactly 3 cycles, same result.
  - flush at the DONE cycle: no we pulse, ready_in = 1 next cycle.
- rd = 0: MUL 2*3 gives valid_out = 1 with we = 0.
- Back-to-back: valid_in held high gives an accept the cycle after DONE.
